mem_loader: RTL and testbench
=============================

Name: mem_loader

Overview:
- Upstream feeder of the memory block's mem_copy port.
- Converts the HPS ioctl byte stream into 16-bit word writes: ROM images go to physical addresses, BK .bin program files go to CPU-virtual addresses.
- Performs a zero-fill of base RAM on cold start.
- Owns write pacing: the memory block gives no acknowledge on mem_copy, so each write is held for a fixed number of cycles and then followed by a mandatory low gap.

Parameters:
- WE_CYCLES, 8: cycles mem_copy_we is held high per word; must be ≥ SDRAM write latency.
- ROM_BASE, 25'hE0000: physical base for ROM image loads.
- CLEAR_END, 25'h20000: exclusive upper physical bound of the cold-start zero-fill.
- BIN_INDEX, 8'd1: ioctl_index value selecting .bin (virtual) mode; any other index selects ROM mode.

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  HPS download window active
- ioctl_index  in  8  file type selector
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  byte offset within file
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  stall request to HPS
- clear_req  in  1  rising edge starts zero-fill
- mem_copy  out  1  memory port ownership
- mem_copy_virt  out  1  1 = address is CPU-virtual
- mem_copy_addr  out  25  word-aligned byte address (bit0 = 0)
- mem_copy_din  out  16  write data
- mem_copy_we  out  1  write strobe
- mem_copy_rd  out  1  read strobe; always 0 unless the optional feature is enabled
- busy  out  1  any operation in progress
- err  out  1  sticky error flag; always 0 unless the optional feature is enabled

Behaviour:
- Clocking and reset:
  - Single clock, clk_sys.
  - rst_n is asynchronous, active-low.
  - On reset, every output is 0, the FSM returns to IDLE, and the byte latch and header registers clear. Reset mid-write drops mem_copy_we immediately; no partial-word recovery is attempted.
- FSM states: IDLE, HDR, COLLECT, WRITE, GAP, CLEAR, FLUSH.
- IDLE:
  - Rising edge of clear_req → CLEAR. This takes priority over a simultaneous download start.
  - Rising edge of ioctl_download → HDR if ioctl_index == BIN_INDEX, otherwise COLLECT.
- HDR (.bin header):
  - Bytes 0..3 form load_addr (little-endian, bit0 forced to 0) and length.
  - After byte 3 → COLLECT.
- COLLECT:
  - For a data byte with offset o (ROM mode: o = ioctl_addr; bin mode: o = ioctl_addr − 4):
    - o even: latch it as the low byte.
    - o odd: form the word {byte, low} → WRITE.
  - In bin mode, bytes with o ≥ length are ignored.
- Address generation:
  - ROM mode: mem_copy_addr = ROM_BASE + {o[24:1], 1'b0}, mem_copy_virt = 0.
  - Bin mode: mem_copy_addr = {9'b0, (load_addr + {o[15:1], 1'b0})[15:0]}, mem_copy_virt = 1. Addition is 16-bit and wraps at 0o177777.
- WRITE:
  - mem_copy_we = 1 for exactly WE_CYCLES cycles.
  - Address and data are stable for the whole interval.
  - Then → GAP.
- GAP:
  - mem_copy_we = 0 for 1 cycle, so the consumer sees a fresh rising edge on the next write.
  - Then → COLLECT (or → FLUSH if download has ended, or → CLEAR/IDLE while in clear mode).
- CLEAR:
  - Writes 16'h0000 to physical addresses 0, 2, … CLEAR_END−2.
  - Each word uses the WRITE/GAP pacing.
  - Returns to IDLE after the last word.
  - A download edge arriving during CLEAR is remembered and serviced after CLEAR completes.
- Download end:
  - On the falling edge of ioctl_download with an unpaired low byte pending → FLUSH.
  - FLUSH writes {8'h00, low} at the next word address, then → IDLE.
- Outputs during operation:
  - mem_copy = busy = 1 in every state except IDLE.
  - ioctl_wait = 1 in WRITE, GAP, CLEAR and FLUSH, and for one cycle after each odd byte strobe.
- Byte strobes:
  - ioctl_wr arriving while ioctl_wait = 1 is a protocol violation and is dropped.
  - The HPS honours ioctl_wait one cycle late, so the extra wait cycle after an odd byte covers that latency.

Optional Feature:
- Macro: MEM_LOADER_VERIFY_EN.
- When defined:
  - After each GAP, a VERIFY state asserts mem_copy_rd for WE_CYCLES cycles at the same address.
  - It then compares mem_copy_dout (extra input, 16 bits) with the written word.
  - A mismatch sets err, which stays set until reset or the next download start.
- When undefined: no VERIFY state, no mem_copy_dout port, mem_copy_rd and err tied to 0.

Decomposition:
- Package mem_loader_pkg:
  - FSM state enum.
  - ROM_BASE and CLEAR_END defaults, BIN_INDEX.
  - BIN_HDR_BYTES = 4.
- Sub-module ioctl_packer:
  - Byte-to-word assembly, pending-byte tracking and offset computation.
  - Emits word_valid/word/word_offset to the FSM.

Test Plan:
- ROM load: index 0, bytes 0x11, 0x22, 0x33, 0x44 at offsets 0–3 → writes 16'h2211 @ 25'hE0000 and 16'h4433 @ 25'hE0002, virt = 0; each we high exactly 8 cycles with a 1-cycle gap.
- Bin load: index 1, header 0x00 0x02 0x03 0x00 (load 0o1000, length 3), data AA BB CC DD → 16'hBBAA @ 0x200, then FLUSH writes 16'h00CC @ 0x202; byte DD is ignored; virt = 1.
- Wrap: bin load_addr 0xFFFE, 4 data bytes → second word lands at address 0x0000.
- Clear: pulse clear_req → 0x10000 writes of 0, last at 25'h1FFFE; busy drops afterwards. A download started mid-clear stays stalled via ioctl_wait and loads after the clear completes.
- Reset mid-WRITE: deassert rst_n while we = 1 → all outputs 0 asynchronously; after release the FSM is IDLE and the next download behaves normally.
- With MEM_LOADER_VERIFY_EN: stub returns the wrong readback → err = 1 after VERIFY; err clears at the next download start.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared types and defaults for the mem_loader HPS-download-to-mem_copy bridge.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_COLLECT,
    S_WRITE,
    S_GAP,
    S_CLEAR,
    S_FLUSH,
    S_VERIFY
  } state_e;

  localparam logic [24:0] ROM_BASE_DEF  = 25'hE0000;
  localparam logic [24:0] CLEAR_END_DEF = 25'h20000;
  localparam logic [7:0]  BIN_INDEX_DEF = 8'd1;
  localparam int          BIN_HDR_BYTES = 4;

  // ROM images land at a physical base; .bin data is CPU-virtual and wraps at 16 bits.
  function automatic logic [24:0] word_addr(input logic        bin,
                                            input logic [24:0] rom_base,
                                            input logic [15:0] load_addr,
                                            input logic [24:0] offset);
    logic [15:0] v;
    v = load_addr + {offset[15:1], 1'b0};
    return bin ? {9'b0, v} : rom_base + {offset[24:1], 1'b0};
  endfunction

endpackage

// File: rtl/mem_loader_ioctl_packer.sv
// Pairs ioctl bytes into 16-bit words and tracks an unpaired low byte for the final flush.
module ioctl_packer
  import mem_loader_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_wr,
  input  logic        i_bin,
  input  logic [24:0] i_addr,
  input  logic [7:0]  i_dout,
  input  logic [15:0] i_length,
  input  logic        i_take,
  output logic        o_word_valid,
  output logic [15:0] o_word,
  output logic [24:0] o_word_offset,
  output logic        o_odd_strobe,
  output logic        o_pending,
  output logic [7:0]  o_pend_low
);

  logic [24:0] w_offset;
  logic        w_in_range;
  logic        w_accept;
  logic        r_valid;
  logic        r_odd;
  logic        r_pending;
  logic [7:0]  r_low;
  logic [15:0] r_word;
  logic [24:0] r_offset;

  // Bin files carry a 4-byte header, so data offsets start after it; bytes past length are dropped.
  assign w_offset   = i_bin ? i_addr - 25'(BIN_HDR_BYTES) : i_addr;
  assign w_in_range = !i_bin ||
                      ((i_addr >= 25'(BIN_HDR_BYTES)) && (w_offset < {9'b0, i_length}));
  assign w_accept   = i_wr && w_in_range;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_odd     <= 1'b0;
      r_pending <= 1'b0;
      r_low     <= 8'h00;
      r_word    <= 16'h0000;
      r_offset  <= 25'd0;
    end else begin
      r_valid <= 1'b0;
      r_odd   <= i_wr && w_offset[0];
      if (i_clr) begin
        r_pending <= 1'b0;
        r_low     <= 8'h00;
      end else if (w_accept) begin
        r_offset <= {w_offset[24:1], 1'b0};
        if (!w_offset[0]) begin
          r_low     <= i_dout;
          r_pending <= 1'b1;
        end else begin
          r_word    <= {i_dout, r_low};
          r_valid   <= 1'b1;
          r_pending <= 1'b0;
        end
      end else if (i_take) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_word_valid  = r_valid;
  assign o_word        = r_word;
  assign o_word_offset = r_offset;
  assign o_odd_strobe  = r_odd;
  assign o_pending     = r_pending;
  assign o_pend_low    = r_low;

endmodule

// File: rtl/mem_loader.sv
// HPS ioctl download and cold-start zero-fill feeder for the memory mem_copy port.
// Optional write-readback check: define MEM_LOADER_VERIFY_EN.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int          WE_CYCLES = 8,
  parameter logic [24:0] ROM_BASE  = ROM_BASE_DEF,
  parameter logic [24:0] CLEAR_END = CLEAR_END_DEF,
  parameter logic [7:0]  BIN_INDEX = BIN_INDEX_DEF
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        clear_req,
  output logic        mem_copy,
  output logic        mem_copy_virt,
  output logic [24:0] mem_copy_addr,
  output logic [15:0] mem_copy_din,
  output logic        mem_copy_we,
  output logic        mem_copy_rd,
`ifdef MEM_LOADER_VERIFY_EN
  input  logic [15:0] mem_copy_dout,
`endif
  output logic        busy,
  output logic        err,
  output state_e      dbg_state
);

  // Handshakes: a byte is taken when ioctl_wr=1 and ioctl_wait=0 in the same cycle, otherwise
  // it is dropped. mem_copy has no acknowledge: each word holds we for WE_CYCLES cycles, then
  // we is low for at least one cycle before the next word.

  state_e      r_state, w_next;
  logic        r_dl_q, r_clr_q, r_bin, r_virt, r_clear_mode, r_dl_pend;
  logic [15:0] r_load_addr, r_length, r_din;
  logic [24:0] r_addr;
  logic [7:0]  r_cnt;

  logic        w_dl_rise, w_clr_rise, w_byte_ok, w_hdr_byte, w_cnt_last;
  logic        w_dl_start, w_clr_start, w_ld_word, w_ld_flush, w_clr_step, w_clr_done;
  logic        w_word_done;
  logic        w_word_valid, w_odd_strobe, w_pending;
  logic [15:0] w_word;
  logic [24:0] w_word_offset;
  logic [7:0]  w_pend_low;

  assign w_dl_rise  = ioctl_download && !r_dl_q;
  assign w_clr_rise = clear_req && !r_clr_q;
  assign w_byte_ok  = ioctl_wr && !ioctl_wait &&
                      ((r_state == S_HDR) || (r_state == S_COLLECT));
  assign w_hdr_byte = w_byte_ok && (r_state == S_HDR) && (ioctl_addr < 25'(BIN_HDR_BYTES));
  assign w_cnt_last = (r_cnt == 8'(WE_CYCLES - 1));

  ioctl_packer u_packer (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .i_clr         (w_dl_start),
    .i_wr          (w_byte_ok && (r_state == S_COLLECT)),
    .i_bin         (r_bin),
    .i_addr        (ioctl_addr),
    .i_dout        (ioctl_dout),
    .i_length      (r_length),
    .i_take        (w_ld_flush),
    .o_word_valid  (w_word_valid),
    .o_word        (w_word),
    .o_word_offset (w_word_offset),
    .o_odd_strobe  (w_odd_strobe),
    .o_pending     (w_pending),
    .o_pend_low    (w_pend_low)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_dl_start  = 1'b0;
    w_clr_start = 1'b0;
    w_ld_word   = 1'b0;
    w_ld_flush  = 1'b0;
    w_clr_step  = 1'b0;
    w_clr_done  = 1'b0;
    w_word_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_clr_rise) begin
          w_next      = S_CLEAR;
          w_clr_start = 1'b1;
        end else if (w_dl_rise) begin
          w_dl_start = 1'b1;
        end
      end
      S_HDR: begin
        if (w_hdr_byte && (ioctl_addr == 25'(BIN_HDR_BYTES - 1))) w_next = S_COLLECT;
        else if (!ioctl_download)                                 w_next = S_IDLE;
      end
      S_COLLECT: begin
        if (w_word_valid) begin
          w_next    = S_WRITE;
          w_ld_word = 1'b1;
        end else if (!ioctl_download && !w_byte_ok) begin
          w_next = w_pending ? S_FLUSH : S_IDLE;
        end
      end
      S_WRITE: if (w_cnt_last) w_next = S_GAP;
`ifdef MEM_LOADER_VERIFY_EN
      S_GAP:    w_next = S_VERIFY;
      S_VERIFY: w_word_done = w_cnt_last;
`else
      S_GAP:    w_word_done = 1'b1;
      S_VERIFY: w_next = S_IDLE;
`endif
      S_CLEAR: w_next = S_WRITE;
      S_FLUSH: begin
        w_next     = S_WRITE;
        w_ld_flush = 1'b1;
      end
    endcase
    // Decides where a finished word goes next, shared by the GAP and VERIFY endings.
    if (w_word_done) begin
      if (r_clear_mode) begin
        if (r_addr == CLEAR_END - 25'd2) begin
          w_clr_done = 1'b1;
          if (r_dl_pend && ioctl_download) w_dl_start = 1'b1;
          else                             w_next = S_IDLE;
        end else begin
          w_clr_step = 1'b1;
          w_next     = S_CLEAR;
        end
      end else if (!ioctl_download) begin
        w_next = w_pending ? S_FLUSH : S_IDLE;
      end else begin
        w_next = S_COLLECT;
      end
    end
    if (w_dl_start) w_next = (ioctl_index == BIN_INDEX) ? S_HDR : S_COLLECT;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_dl_q       <= 1'b0;
      r_clr_q      <= 1'b0;
      r_bin        <= 1'b0;
      r_virt       <= 1'b0;
      r_clear_mode <= 1'b0;
      r_dl_pend    <= 1'b0;
      r_load_addr  <= 16'h0000;
      r_length     <= 16'h0000;
      r_din        <= 16'h0000;
      r_addr       <= 25'd0;
      r_cnt        <= 8'd0;
    end else begin
      r_dl_q  <= ioctl_download;
      r_clr_q <= clear_req;
      r_cnt   <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
      if (w_dl_start) begin
        r_bin       <= (ioctl_index == BIN_INDEX);
        r_load_addr <= 16'h0000;
        r_length    <= 16'h0000;
        r_dl_pend   <= 1'b0;
      end else if (w_dl_rise && (r_clear_mode || w_clr_start)) begin
        r_dl_pend <= 1'b1;
      end
      if (w_hdr_byte) begin
        unique case (ioctl_addr[1:0])
          2'd0: r_load_addr[7:0]  <= {ioctl_dout[7:1], 1'b0};
          2'd1: r_load_addr[15:8] <= ioctl_dout;
          2'd2: r_length[7:0]     <= ioctl_dout;
          2'd3: r_length[15:8]    <= ioctl_dout;
        endcase
      end
      if (w_clr_start) begin
        r_clear_mode <= 1'b1;
        r_addr       <= 25'd0;
        r_din        <= 16'h0000;
        r_virt       <= 1'b0;
      end else if (w_clr_step) begin
        r_addr <= r_addr + 25'd2;
      end else if (w_ld_word) begin
        r_addr <= word_addr(r_bin, ROM_BASE, r_load_addr, w_word_offset);
        r_din  <= w_word;
        r_virt <= r_bin;
      end else if (w_ld_flush) begin
        r_addr <= word_addr(r_bin, ROM_BASE, r_load_addr, w_word_offset);
        r_din  <= {8'h00, w_pend_low};
        r_virt <= r_bin;
      end
      if (w_clr_done) r_clear_mode <= 1'b0;
    end
  end

`ifdef MEM_LOADER_VERIFY_EN
  logic r_err;
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                                  r_err <= 1'b0;
    else if (w_dl_start)                         r_err <= 1'b0;
    else if ((r_state == S_VERIFY) && w_cnt_last && (mem_copy_dout != r_din))
                                                 r_err <= 1'b1;
  end
  assign err         = r_err;
  assign mem_copy_rd = (r_state == S_VERIFY);
`else
  assign err         = 1'b0;
  assign mem_copy_rd = 1'b0;
`endif

  assign busy          = (r_state != S_IDLE);
  assign mem_copy      = busy;
  assign mem_copy_we   = (r_state == S_WRITE);
  assign mem_copy_addr = r_addr;
  assign mem_copy_din  = r_din;
  assign mem_copy_virt = r_virt;
  assign ioctl_wait    = (r_state == S_WRITE) || (r_state == S_GAP) || (r_state == S_CLEAR) ||
                         (r_state == S_FLUSH) || (r_state == S_VERIFY) || w_odd_strobe;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: ROM, bin, wrap, clear-with-pending-download and reset-mid-write.
module tb_mem_loader;
  import mem_loader_pkg::*;

  localparam int          WE        = 8;
  localparam logic [24:0] CLR_END   = 25'h40;
  localparam int          CLR_WORDS = 32;
  localparam int          TMO       = 3000;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        ioctl_download, ioctl_wr, clear_req;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        ioctl_wait, mem_copy, mem_copy_virt, mem_copy_we, mem_copy_rd, busy, err;
  logic [24:0] mem_copy_addr;
  logic [15:0] mem_copy_din;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [41:0] exp_q[$];

  mem_loader #(.WE_CYCLES(WE), .CLEAR_END(CLR_END)) dut (
    .clk_sys        (clk_sys),
    .rst_n          (rst_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .clear_req      (clear_req),
    .mem_copy       (mem_copy),
    .mem_copy_virt  (mem_copy_virt),
    .mem_copy_addr  (mem_copy_addr),
    .mem_copy_din   (mem_copy_din),
    .mem_copy_we    (mem_copy_we),
    .mem_copy_rd    (mem_copy_rd),
    .busy           (busy),
    .err            (err),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic v, input logic [24:0] a, input logic [15:0] d);
    exp_q.push_back({v, a, d});
  endtask

  // driver tasks
  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int t;
    t = 0;
    @(posedge clk_sys); #1;
    while (ioctl_wait && t < TMO) begin
      @(posedge clk_sys); #1;
      t++;
    end
    chk("byte_wait_bound", 64'(t < TMO), 64'd1);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < TMO) begin
      @(posedge clk_sys); #1;
      t++;
    end
    chk(tag, 64'(t < TMO), 64'd1);
  endtask

  // scoreboard: pop on each rising we, check hold stability and we width
  logic        we_prev = 1'b0;
  int          we_len  = 0;
  logic [41:0] cur_w, exp_w;
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      we_prev = 1'b0;
      we_len  = 0;
    end else begin
      if (mem_copy_we && !we_prev) begin
        we_len = 1;
        cur_w  = {mem_copy_virt, mem_copy_addr, mem_copy_din};
        chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          chk("write_word", 64'(cur_w), 64'(exp_w));
        end
        chk("write_busy_rd_err", {61'd0, mem_copy, busy, mem_copy_rd | err}, 64'b110);
      end else if (mem_copy_we) begin
        we_len++;
        chk("write_hold", 64'({mem_copy_virt, mem_copy_addr, mem_copy_din}), 64'(cur_w));
      end else if (we_prev) begin
        chk("we_width", 64'(we_len), 64'(WE));
      end
      we_prev = mem_copy_we;
    end
  end

  initial begin
    int t;
    rst_n          = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'd0;
    clear_req      = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset_outputs", {45'd0, ioctl_wait, mem_copy, mem_copy_virt, mem_copy_we, mem_copy_rd,
                          busy, err, mem_copy_din}, 64'd0);
    chk("reset_addr", 64'(mem_copy_addr), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(S_IDLE));
    rst_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;

    // ROM load
    push(1'b0, 25'hE0000, 16'h2211);
    push(1'b0, 25'hE0002, 16'h4433);
    start_dl(8'd0);
    chk("rom_busy", {62'd0, busy, mem_copy}, 64'b11);
    send_byte(25'd0, 8'h11);
    send_byte(25'd1, 8'h22);
    send_byte(25'd2, 8'h33);
    send_byte(25'd3, 8'h44);
    ioctl_download = 1'b0;
    wait_idle("rom_idle");
    chk("rom_drained", 64'(exp_q.size()), 64'd0);

    // bin load with length 3: last byte flushed, fourth byte ignored
    push(1'b1, 25'h200, 16'hBBAA);
    push(1'b1, 25'h202, 16'h00CC);
    start_dl(8'd1);
    send_byte(25'd0, 8'h00);
    send_byte(25'd1, 8'h02);
    send_byte(25'd2, 8'h03);
    send_byte(25'd3, 8'h00);
    send_byte(25'd4, 8'hAA);
    send_byte(25'd5, 8'hBB);
    send_byte(25'd6, 8'hCC);
    send_byte(25'd7, 8'hDD);
    ioctl_download = 1'b0;
    wait_idle("bin_idle");
    chk("bin_drained", 64'(exp_q.size()), 64'd0);

    // bin wrap at 16 bits; odd load address has bit0 forced low
    push(1'b1, 25'h0FFFE, 16'h0201);
    push(1'b1, 25'h00000, 16'h0403);
    start_dl(8'd1);
    send_byte(25'd0, 8'hFF);
    send_byte(25'd1, 8'hFF);
    send_byte(25'd2, 8'h04);
    send_byte(25'd3, 8'h00);
    for (int i = 0; i < 4; i++) send_byte(25'(4 + i), 8'(i + 1));
    ioctl_download = 1'b0;
    wait_idle("wrap_idle");
    chk("wrap_drained", 64'(exp_q.size()), 64'd0);

    // clear with a ROM download started mid-clear
    for (int i = 0; i < CLR_WORDS; i++) push(1'b0, 25'(2 * i), 16'h0000);
    push(1'b0, 25'hE0000, 16'h6655);
    clear_req = 1'b1;
    @(posedge clk_sys); #1;
    clear_req = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("clear_busy_wait", {62'd0, busy, ioctl_wait}, 64'b11);
    start_dl(8'd0);
    chk("clear_stall", {62'd0, busy, ioctl_wait}, 64'b11);
    send_byte(25'd0, 8'h55);
    chk("clear_done_before_data", 64'(exp_q.size()), 64'd1);
    send_byte(25'd1, 8'h66);
    ioctl_download = 1'b0;
    wait_idle("clear_idle");
    chk("clear_drained", 64'(exp_q.size()), 64'd0);

    // reset in the middle of a write
    push(1'b0, 25'hE0000, 16'hA55A);
    start_dl(8'd0);
    send_byte(25'd0, 8'h5A);
    send_byte(25'd1, 8'hA5);
    t = 0;
    while (!mem_copy_we && t < TMO) begin
      @(posedge clk_sys); #1;
      t++;
    end
    chk("rst_we_seen", 64'(t < TMO), 64'd1);
    @(posedge clk_sys);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {45'd0, ioctl_wait, mem_copy, mem_copy_virt, mem_copy_we, mem_copy_rd,
                              busy, err, mem_copy_din}, 64'd0);
    chk("rst_async_addr", 64'(mem_copy_addr), 64'd0);
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 rst_n = 1'b1;
    @(posedge clk_sys); #1;
    chk("rst_state_idle", 64'(dbg_state), 64'(S_IDLE));
    chk("rst_cut_popped", 64'(exp_q.size()), 64'd0);

    push(1'b0, 25'hE0000, 16'h8877);
    start_dl(8'd0);
    send_byte(25'd0, 8'h77);
    send_byte(25'd1, 8'h88);
    ioctl_download = 1'b0;
    wait_idle("post_rst_idle");
    chk("post_rst_drained", 64'(exp_q.size()), 64'd0);
    chk("final_state", 64'(dbg_state), 64'(S_IDLE));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
